deserializer_multilane: RTL and testbench
=========================================

Name: deserializer_multilane

Overview:
Generalised serial-to-parallel converter for the FIR filter input path. It accepts LANES bits per enabled beat and assembles LENGTH-bit words, framed by an explicit start-of-word marker. Bit order is selectable. Completed words are presented on a valid/ready output with overflow and framing-error reporting. It sits between the serial sample interface and the filter datapath, and replaces single-bit, unframed deserialisation.

Parameters:
LENGTH, 24, output word width in bits; must be a multiple of LANES and ≥ 2*LANES
LANES, 2, input bits per beat (1, 2, 4, 8…)
MSB_FIRST, 0, 0 = first beat fills LSBs; 1 = first beat fills MSBs

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  beat qualifier; iv_din/i_frame sampled only when high
iv_din  input  LANES  serial data beat
i_frame  input  1  marks the current beat as the first beat of a word (qualified by i_en)
i_clr_ovf  input  1  synchronous clear of o_overflow
ov_dout  output  LENGTH  assembled word
o_dout_valid  output  1  ov_dout holds an unconsumed word
i_dout_ready  input  1  downstream accepts word when high with o_dout_valid
o_overflow  output  1  sticky: a completed word was dropped
o_sync_err  output  1  one-cycle pulse: i_frame arrived mid-word

Behaviour:
- Reset (i_rst_n low, async): ov_dout=0, o_dout_valid=0, o_overflow=0, o_sync_err=0, shift register=0, beat counter=0, state=HUNT.
- BEATS = LENGTH/LANES. A beat = cycle with i_en=1. Cycles with i_en=0 change nothing on the input side: counter, shift register and state hold.
- FSM HUNT: beats without i_frame are discarded. A beat with i_frame stores beat 0, sets counter=1 and moves to ACQ.
- FSM ACQ, beat without i_frame: store beat at index=counter, counter+1. On the beat where counter==BEATS-1, the word completes: counter->0, state->HUNT.
- FSM ACQ, beat with i_frame: partial word discarded; o_sync_err=1 for the next cycle; this beat becomes beat 0 (counter=1, stay ACQ).
- LANES == LENGTH is not allowed (BEATS ≥ 2).
- Placement, MSB_FIRST=0: beat k occupies bits [k*LANES+LANES-1 : k*LANES], with iv_din[i] -> bit k*LANES+i.
- Placement, MSB_FIRST=1: beat k occupies bits [LENGTH-1-k*LANES : LENGTH-k*LANES-LANES], with iv_din[LANES-1] the most significant bit of that slice.
- Output latency: ov_dout/o_dout_valid update on the clock edge that accepts the final beat, so they are visible the cycle after that beat is presented.
- Output handshake: a word transfers when o_dout_valid && i_dout_ready. While valid and not ready, ov_dout is stable. o_dout_valid drops the cycle after transfer unless a new word loads.
- Word completes while o_dout_valid=1 and i_dout_ready=1 in the same cycle: the new word loads, valid stays 1, no overflow.
- Word completes while o_dout_valid=1 and i_dout_ready=0: the new word is dropped, ov_dout unchanged, o_overflow set (sticky).
- i_clr_ovf=1 clears o_overflow; if a drop occurs in the same cycle, set wins.
- o_sync_err is registered, high for exactly one cycle per event.
- Reset asserted mid-word or with a pending output word: everything is cleared immediately; the pending word is lost and not reported as overflow.

Test Plan:
1. LENGTH=8, LANES=2, MSB_FIRST=0, ready=1: beats 01(frame),10,11,00 -> ov_dout=0x39 with o_dout_valid=1 for one cycle, the cycle after the 4th beat.
2. Same beats with MSB_FIRST=1 -> ov_dout=0x6C; then insert i_en=0 gaps between beats -> same result, valid delayed by the gap count.
3. Hold ready=0 and send two framed words (0x39, then 0xFF) -> ov_dout stays 0x39, o_overflow=1; assert i_clr_ovf -> o_overflow=0; ready=1 -> one transfer of 0x39.
4. Send 2 beats, then a beat with i_frame -> o_sync_err pulses 1 cycle, partial discarded; next 3 beats 10,11,00 complete -> 0x39 (with 01 as the framed beat).
5. Beats before any i_frame (11,11) -> ignored, no valid; then a framed word -> correct word only.
6. Assert i_rst_n=0 asynchronously mid-word (between edges) and while valid is pending -> all outputs 0 immediately; after release, a new framed word 0x39 assembles correctly.

Source files
------------

// File: rtl/deserializer_multilane.sv
// Framed multi-lane serial-to-parallel converter: LANES bits per enabled beat, LENGTH-bit words,
// valid/ready output with sticky overflow and mid-word framing-error pulse.
module deserializer_multilane #(
    parameter int unsigned LENGTH    = 24,
    parameter int unsigned LANES     = 2,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [LANES-1:0]  iv_din,
    input  logic              i_frame,
    input  logic              i_clr_ovf,
    output logic [LENGTH-1:0] ov_dout,
    output logic              o_dout_valid,
    input  logic              i_dout_ready,
    output logic              o_overflow,
    output logic              o_sync_err
);

    localparam int unsigned BEATS  = LENGTH / LANES;
    localparam int unsigned CNT_W  = $clog2(BEATS);
    localparam int unsigned BASE_W = $clog2(LENGTH);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if ((LENGTH % LANES) != 0 || LENGTH < 2 * LANES) begin : g_bad_params
        $error("deserializer_multilane: LENGTH must be a multiple of LANES and >= 2*LANES");
    end

    typedef enum logic {
        StHunt,
        StAcq
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [LENGTH-1:0]   r_shift;
    logic [LENGTH-1:0]   r_dout;
    logic                r_valid;
    logic                r_overflow;
    logic                r_sync_err;

    logic [CNT_W-1:0]    w_idx;
    logic [BASE_W-1:0]   w_base;
    logic [LENGTH-1:0]   w_shift_next;
    logic                w_complete;
    logic                w_drop;

    // A framed beat always restarts at slot 0 with the stale partial word cleared.
    assign w_idx      = i_frame ? '0 : r_cnt;
    assign w_complete = i_en && !i_frame && (r_state == StAcq) && (r_cnt == LAST_BEAT);
    assign w_drop     = w_complete && r_valid && !i_dout_ready;

    always_comb begin
        w_base = '0;
        if (MSB_FIRST != 0) begin
            w_base = BASE_W'(LENGTH - (32'(w_idx) + 32'd1) * LANES);
        end else begin
            w_base = BASE_W'(32'(w_idx) * LANES);
        end
        w_shift_next = i_frame ? '0 : r_shift;
        w_shift_next[w_base +: LANES] = iv_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StHunt;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= 1'b0;
            if (i_en) begin
                case (r_state)
                    StHunt: begin
                        if (i_frame) begin
                            r_shift <= w_shift_next;
                            r_cnt   <= CNT_W'(1);
                            r_state <= StAcq;
                        end
                    end
                    StAcq: begin
                        r_shift <= w_shift_next;
                        if (i_frame) begin
                            r_cnt      <= CNT_W'(1);
                            r_sync_err <= 1'b1;
                        end else if (r_cnt == LAST_BEAT) begin
                            r_cnt   <= '0;
                            r_state <= StHunt;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= StHunt;
                endcase
            end

            // A completing word may replace one being consumed this same cycle.
            if (w_complete && (!r_valid || i_dout_ready)) begin
                r_dout  <= w_shift_next;
                r_valid <= 1'b1;
            end else if (r_valid && i_dout_ready) begin
                r_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign ov_dout      = r_dout;
    assign o_dout_valid = r_valid;
    assign o_overflow   = r_overflow;
    assign o_sync_err   = r_sync_err;

endmodule

// File: tb/tb_deserializer_multilane.sv
// Scoreboard bench: two LENGTH=8, LANES=2 instances (LSB-first and MSB-first) share one stimulus
// stream; expected words are queued per instance and popped by a monitor on each transfer.
module tb_deserializer_multilane;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] din;
    logic       frame;
    logic       clr;
    logic       ready;

    logic [7:0] dout0, dout1;
    logic       v0, v1, ovf0, ovf1, se0, se1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    deserializer_multilane #(.LENGTH(8), .LANES(2), .MSB_FIRST(0)) u_lsb (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .iv_din       (din),
        .i_frame      (frame),
        .i_clr_ovf    (clr),
        .ov_dout      (dout0),
        .o_dout_valid (v0),
        .i_dout_ready (ready),
        .o_overflow   (ovf0),
        .o_sync_err   (se0)
    );

    deserializer_multilane #(.LENGTH(8), .LANES(2), .MSB_FIRST(1)) u_msb (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .iv_din       (din),
        .i_frame      (frame),
        .i_clr_ovf    (clr),
        .ov_dout      (dout1),
        .o_dout_valid (v1),
        .i_dout_ready (ready),
        .o_overflow   (ovf1),
        .o_sync_err   (se1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every transfer must match the oldest queued word of its instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ready === 1'b1) begin
            if (v0 === 1'b1) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dout_lsb: got 0x%0h expected no word at %0t", dout0, $time);
                end else begin
                    chk("dout_lsb", {24'd0, dout0}, {24'd0, q0.pop_front()});
                end
            end
            if (v1 === 1'b1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dout_msb: got 0x%0h expected no word at %0t", dout1, $time);
                end else begin
                    chk("dout_msb", {24'd0, dout1}, {24'd0, q1.pop_front()});
                end
            end
        end
    end

    task automatic beat(input logic [1:0] d, input logic f);
        en    = 1'b1;
        din   = d;
        frame = f;
        @(posedge clk);
        #1;
        en    = 1'b0;
        frame = 1'b0;
        din   = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic word(input logic [1:0] b0, input logic [1:0] b1, input logic [1:0] b2,
                        input logic [1:0] b3);
        beat(b0, 1'b1);
        beat(b1, 1'b0);
        beat(b2, 1'b0);
        beat(b3, 1'b0);
    endtask

    task automatic push(input logic [7:0] e0, input logic [7:0] e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 1'b0; din = 2'b00; frame = 1'b0; clr = 1'b0; ready = 1'b1; rst_n = 1'b0;
        #12;
        chk("rst_dout_lsb", {24'd0, dout0}, 32'h0);
        chk("rst_dout_msb", {24'd0, dout1}, 32'h0);
        chk("rst_valid", {31'd0, v0}, 32'd0);
        chk("rst_ovf", {31'd0, ovf0}, 32'd0);
        chk("rst_sync", {31'd0, se0}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic word, both bit orders, back-to-back beats.
        push(8'h39, 8'h6C);
        beat(2'b01, 1'b1);
        chk("sync_first_frame", {31'd0, se0}, 32'd0);
        beat(2'b10, 1'b0);
        beat(2'b11, 1'b0);
        chk("valid_early", {31'd0, v0}, 32'd0);
        beat(2'b00, 1'b0);
        chk("valid_latency_lsb", {31'd0, v0}, 32'd1);
        chk("valid_latency_msb", {31'd0, v1}, 32'd1);
        idle(1);
        chk("valid_drop", {31'd0, v0}, 32'd0);

        // Same word with i_en gaps between beats.
        push(8'h39, 8'h6C);
        beat(2'b01, 1'b1);
        idle(2);
        beat(2'b10, 1'b0);
        idle(1);
        beat(2'b11, 1'b0);
        idle(3);
        chk("gap_no_valid", {31'd0, v1}, 32'd0);
        beat(2'b00, 1'b0);
        chk("gap_valid", {31'd0, v1}, 32'd1);
        idle(1);

        // Backpressure: second word dropped, overflow sticky until cleared.
        ready = 1'b0;
        push(8'h39, 8'h6C);
        word(2'b01, 2'b10, 2'b11, 2'b00);
        chk("ovf_none_yet", {31'd0, ovf0}, 32'd0);
        word(2'b11, 2'b11, 2'b11, 2'b11);
        chk("ovf_set_lsb", {31'd0, ovf0}, 32'd1);
        chk("ovf_set_msb", {31'd0, ovf1}, 32'd1);
        chk("hold_dout_lsb", {24'd0, dout0}, 32'h39);
        chk("hold_dout_msb", {24'd0, dout1}, 32'h6C);
        idle(2);
        chk("ovf_sticky", {31'd0, ovf0}, 32'd1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("ovf_cleared", {31'd0, ovf0}, 32'd0);
        ready = 1'b1;
        idle(1);
        chk("drained", {31'd0, v0}, 32'd0);

        // Drop coinciding with i_clr_ovf: set wins.
        ready = 1'b0;
        push(8'h39, 8'h6C);
        word(2'b01, 2'b10, 2'b11, 2'b00);
        beat(2'b11, 1'b1);
        beat(2'b11, 1'b0);
        beat(2'b11, 1'b0);
        clr = 1'b1;
        beat(2'b11, 1'b0);
        clr = 1'b0;
        chk("ovf_set_wins", {31'd0, ovf0}, 32'd1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        ready = 1'b1;
        idle(1);

        // Frame mid-word: sync error pulse, partial word discarded.
        push(8'h39, 8'h6C);
        beat(2'b01, 1'b1);
        beat(2'b10, 1'b0);
        beat(2'b01, 1'b1);
        chk("sync_pulse_lsb", {31'd0, se0}, 32'd1);
        chk("sync_pulse_msb", {31'd0, se1}, 32'd1);
        beat(2'b10, 1'b0);
        chk("sync_one_cycle", {31'd0, se0}, 32'd0);
        beat(2'b11, 1'b0);
        beat(2'b00, 1'b0);
        idle(1);

        // Unframed beats in HUNT are ignored.
        beat(2'b11, 1'b0);
        beat(2'b11, 1'b0);
        chk("hunt_discard", {31'd0, v0}, 32'd0);
        push(8'h39, 8'h6C);
        word(2'b01, 2'b10, 2'b11, 2'b00);
        idle(1);

        // Async reset with a pending word, overflow set and a partial word in flight.
        ready = 1'b0;
        word(2'b01, 2'b10, 2'b11, 2'b00);
        word(2'b11, 2'b11, 2'b11, 2'b11);
        chk("pre_rst_valid", {31'd0, v0}, 32'd1);
        chk("pre_rst_ovf", {31'd0, ovf0}, 32'd1);
        beat(2'b01, 1'b1);
        beat(2'b10, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_dout_lsb", {24'd0, dout0}, 32'h0);
        chk("arst_dout_msb", {24'd0, dout1}, 32'h0);
        chk("arst_valid", {31'd0, v0}, 32'd0);
        chk("arst_ovf", {31'd0, ovf1}, 32'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b1;
        push(8'h39, 8'h6C);
        word(2'b01, 2'b10, 2'b11, 2'b00);
        chk("post_rst_valid", {31'd0, v0}, 32'd1);
        idle(1);
        chk("post_rst_drop", {31'd0, v0}, 32'd0);

        idle(2);
        chk("queue_empty_lsb", q0.size(), 32'd0);
        chk("queue_empty_msb", q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
